// File: rtl/round_robin_arbiter_pkg.sv
// round_robin_arbiter_pkg: FSM state encodings, default hold limit and the rotating-priority pick function
package round_robin_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, GAP = 2'd2} state_t;
  localparam int HOLD_MAX_DEFAULT = 16;
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/round_robin_arbiter_mux.sv
// Mux4a1: 4-to-1 data multiplexer; selector picks one of in0..in3 onto out
module Mux4a1 #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       selector,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] out
);
  always_comb out = selector[1] ? (selector[0] ? in3 : in2) : (selector[0] ? in1 : in0);
endmodule

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: 4-way round-robin arbiter with hold limit; Clock/Reset_n, Request[3:0], Input0..3 in; Grant, Selector, Output, Valid out
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [3:0]       Request,
  input  logic [WIDTH-1:0] Input0,
  input  logic [WIDTH-1:0] Input1,
  input  logic [WIDTH-1:0] Input2,
  input  logic [WIDTH-1:0] Input3,
  output logic [3:0]       Grant,
  output logic [1:0]       Selector,
  output logic [WIDTH-1:0] Output,
  output logic             Valid
);
  state_t state, state_nx;
  logic [3:0] grant_nx;
  logic [1:0] sel_nx, ptr, ptr_nx, win;
  logic [7:0] count, count_nx;
  logic at_max, drop;
  assign win    = rr_pick(Request, ptr);
  assign at_max = count == 8'(HOLD_MAX);
  assign drop   = !Request[Selector] || (at_max && |(Request & ~Grant));
  assign Valid  = |Grant;
  always_comb begin
    state_nx = state;
    grant_nx = Grant;
    sel_nx   = Selector;
    ptr_nx   = ptr;
    count_nx = count;
    if (state == BUSY) begin
      state_nx = drop ? GAP : BUSY;
      grant_nx = drop ? 4'b0 : Grant;
      ptr_nx   = drop ? Selector + 2'd1 : ptr;
      count_nx = drop ? 8'd0 : (at_max ? 8'd1 : count + 8'd1);
    end else if (|Request) begin
      state_nx = BUSY;
      grant_nx = 4'b1 << win;
      sel_nx   = win;
      count_nx = 8'd1;
    end else begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      Grant    <= 4'b0;
      Selector <= 2'd0;
      ptr      <= 2'd0;
      count    <= 8'd0;
    end else begin
      state    <= state_nx;
      Grant    <= grant_nx;
      Selector <= sel_nx;
      ptr      <= ptr_nx;
      count    <= count_nx;
    end
  end
  Mux4a1 #(.WIDTH(WIDTH)) u_mux (
    .selector(Selector),
    .in0(Input0),
    .in1(Input1),
    .in2(Input2),
    .in3(Input3),
    .out(Output)
  );
endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb_round_robin_arbiter: randomized and directed checks of two arbiter instances (HOLD_MAX 2 and 16) against a behavioural model
module tb_round_robin_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic [7:0] din [4];
  logic [3:0] grant_a, grant_b;
  logic [1:0] sel_a, sel_b;
  logic [7:0] out_a, out_b;
  logic valid_a, valid_b;
  int n_cmp = 0;
  int n_bad = 0;
  int owner [2];
  int held [2];
  int ptr [2];
  int sel [2];
  int hm [2] = '{2, 16};
  always #5 clk = ~clk;
  round_robin_arbiter #(.WIDTH(8), .HOLD_MAX(2)) dut_a (
    .Clock(clk), .Reset_n(rst_n), .Request(req),
    .Input0(din[0]), .Input1(din[1]), .Input2(din[2]), .Input3(din[3]),
    .Grant(grant_a), .Selector(sel_a), .Output(out_a), .Valid(valid_a)
  );
  round_robin_arbiter dut_b (
    .Clock(clk), .Reset_n(rst_n), .Request(req),
    .Input0(din[0]), .Input1(din[1]), .Input2(din[2]), .Input3(din[3]),
    .Grant(grant_b), .Selector(sel_b), .Output(out_b), .Valid(valid_b)
  );
  always @(posedge clk or negedge rst_n) begin
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        owner[m] = -1;
        held[m]  = 0;
        ptr[m]   = 0;
        sel[m]   = 0;
      end else if (owner[m] >= 0) begin
        if (!req[owner[m]] || (held[m] == hm[m] && (req & ~(4'b1 << owner[m])) != 4'b0)) begin
          ptr[m]   = (owner[m] + 1) % 4;
          owner[m] = -1;
          held[m]  = 0;
        end else begin
          held[m] = (held[m] == hm[m]) ? 1 : held[m] + 1;
        end
      end else if (req != 4'b0) begin
        int w;
        w = -1;
        for (int k = 0; k < 4; k++)
          if (w < 0 && req[(ptr[m] + k) % 4]) w = (ptr[m] + k) % 4;
        owner[m] = w;
        sel[m]   = w;
        held[m]  = 1;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      logic [3:0] g;
      logic [3:0] eg;
      logic [1:0] s;
      logic [7:0] o;
      logic v;
      g  = m == 0 ? grant_a : grant_b;
      s  = m == 0 ? sel_a : sel_b;
      o  = m == 0 ? out_a : out_b;
      v  = m == 0 ? valid_a : valid_b;
      eg = owner[m] >= 0 ? 4'b1 << owner[m] : 4'b0;
      chk($sformatf("grant%0d", m), 32'(g), 32'(eg));
      chk($sformatf("selector%0d", m), 32'(s), 32'(sel[m]));
      chk($sformatf("valid%0d", m), 32'(v), 32'(eg != 4'b0));
      chk($sformatf("output%0d", m), 32'(o), 32'(din[sel[m]]));
    end
  endtask
  task automatic step(input logic [3:0] r);
    req = r;
    @(negedge clk);
    check_all();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask
  initial begin
    din = '{8'h11, 8'h22, 8'h33, 8'h44};
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) step(4'b1111);
    din = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b0100);
    for (int i = 0; i < 3; i++) step(4'b0000);
    step(4'b1100);
    step(4'b1100);
    step(4'b1000);
    step(4'b1001);
    for (int i = 0; i < 4; i++) step(4'b0001);
    do_reset();
    for (int i = 0; i < 40; i++) step(4'b0010);
    do_reset();
    step(4'b0100);
    step(4'b0100);
    #2 rst_n = 1'b0;
    #1 check_all();
    #1 rst_n = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    check_all();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      r = req;
      for (int b = 0; b < 4; b++)
        r[b] = r[b] ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
      if ($urandom_range(9) == 0) din[$urandom_range(3)] = 8'($urandom);
      if ($urandom_range(150) == 0) do_reset();
      step(r);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
